bcd_serial_addsub: RTL and testbench
====================================

# bcd_serial_addsub

Digit-serial, multi-digit packed-BCD adder/subtractor with sign-magnitude output. It processes one BCD digit per clock, least-significant digit first, and reuses a single-digit BCD add slice. For subtraction it forms the ten's complement of B. When no end carry results, it runs a second recomplement pass that turns the complement-form difference back into a true magnitude plus a sign. It sits between operand registers and the display/formatting logic, with valid/ready handshakes on both sides.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operands/op present
- start_ready  out  1  block idle, accepting a command
- a  in  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]
- b  in  4*DIGITS  packed BCD operand B
- op  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  4*DIGITS  packed BCD magnitude
- sign  out  1  1 = negative result (subtract only)
- carry_out  out  1  add overflow (decimal carry out of top digit)
- invalid  out  1  an input digit was >9

## Operation
- Clock and reset are fixed as above: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- States: IDLE, PASS1, PASS2, DONE.
  - start_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: start_valid && start_ready at an edge. The block captures a, b and op, and clears the digit index and internal carry.
  - Internal carry starts at op: 1 for subtract, the "+1" of the ten's complement.
- Invalid check at accept: if any digit of a or b is >9, go to DONE with invalid=1, result=0, sign=0, carry_out=0.
- PASS1: one digit per cycle, index 0..DIGITS−1.
  - Digit operand y = b[i] for add.
  - y = 9−b[i] (nine's complement) for subtract.
  - Compute BCD sum z = a[i]+y+carry. If z>9, subtract 10 and set carry=1; otherwise carry=0.
  - Store the digit into the result shift register.
- End of PASS1 (last digit), with c = final carry:
  - Add: carry_out=c, sign=0, go to DONE.
  - Subtract, c=1: A≥B, sign=0, go to DONE.
  - Subtract, c=0: A<B, go to PASS2 with carry=1 and index=0.
- PASS2: per digit, r[i] = (9−r[i]) + carry with BCD correction. This is the ten's complement of the PASS1 result. At the last digit set sign=1 and go to DONE. The final carry of PASS2 is discarded.
- DONE: hold result, sign, carry_out and invalid stable until out_ready. On out_valid && out_ready, go to IDLE.
- The result registers update only when DONE is entered. They keep their values after the handshake until the next DONE entry.
- start_valid outside IDLE is ignored and not queued. There is no same-cycle restart: start_ready rises the cycle after the output handshake.
- A−B with A==B gives 0000 with sign=0. Negative zero cannot occur.
- Arithmetic is modulo 10^DIGITS. Add overflow is reported only through carry_out; result keeps the low DIGITS digits.

## Timing
- Reset (async assert, any state): state=IDLE, start_ready=1 once reset is released, out_valid=0, result=0, sign=0, carry_out=0, invalid=0, internal carry and index cleared. An in-flight operation is abandoned with no output.
- Accept at edge T:
  - Add, or subtract with A≥B: out_valid high after edge T+DIGITS.
  - Subtract with A<B: out_valid high after edge T+2·DIGITS.
  - Invalid input: out_valid high after edge T+1.
- out_ready held low: out_valid and all result outputs stay constant indefinitely.
- Throughput: at most one operation per DIGITS+2 cycles (add, out_ready tied high).

## Test plan
All scenarios use DIGITS=4 with out_ready tied high unless stated.
- op=0, a=1234, b=5678 -> result=6912, carry_out=0, sign=0, out_valid 4 cycles after accept.
- op=0, a=9999, b=0001 -> result=0000, carry_out=1, invalid=0.
- op=1, a=5000, b=1234 -> result=3766, sign=0, latency 4. Then op=1, a=1234, b=5000 -> result=3766, sign=1, latency 8.
- op=1, a=0042, b=0042 -> result=0000, sign=0. Then op=1, a=0000, b=0001 -> result=0001, sign=1.
- a=0x12A4 (digit 0xA) -> invalid=1, result=0, out_valid 1 cycle after accept. Also hold out_ready=0 for 10 cycles -> outputs unchanged, start_ready=0, and a start_valid pulse during this window is ignored.
- Assert rst_n low mid-PASS2 of 1234−5000 -> out_valid=0 and outputs 0 immediately. After release start_ready=1, and a fresh 0001+0002 returns 0003.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor with sign-magnitude result
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   result,
    output logic                  sign,
    output logic                  carry_out,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   work;
    logic [W-1:0]   work_next;
    logic           op_r;
    logic           carry;
    logic           carry_n;
    logic           inv_flag;
    logic [IW-1:0]  idx;
    logic           last;
    logic [3:0]     slice_x;
    logic [3:0]     slice_y;
    logic [4:0]     slice_raw;
    logic [3:0]     slice_digit;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One shared BCD digit slice: PASS1 adds a[i] to b[i] or 9-b[i];
    // PASS2 recomplements the stored digit as (9-r[i]) + carry.
    always_comb begin
        slice_x = a_sh[3:0];
        slice_y = op_r ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
        if (state == PASS2) begin
            slice_x = 4'd9 - work[3:0];
            slice_y = 4'd0;
        end
        slice_raw = {1'b0, slice_x} + {1'b0, slice_y} + {4'd0, carry};
        if (slice_raw > 5'd9) begin
            slice_digit = 4'(slice_raw - 5'd10);
            carry_n     = 1'b1;
        end else begin
            slice_digit = slice_raw[3:0];
            carry_n     = 1'b0;
        end
        work_next = (work >> 4) | (W'(slice_digit) << (W - 4));
        last      = (idx == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_valid) next_state = PASS1;
            PASS1: begin
                if (inv_flag)                next_state = DONE;
                else if (last && op_r && !carry_n) next_state = PASS2;
                else if (last)               next_state = DONE;
            end
            PASS2: if (last) next_state = DONE;
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == IDLE);
        out_valid   = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            work      <= '0;
            op_r      <= 1'b0;
            carry     <= 1'b0;
            inv_flag  <= 1'b0;
            idx       <= '0;
            result    <= '0;
            sign      <= 1'b0;
            carry_out <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    op_r     <= op;
                    carry    <= op;
                    idx      <= '0;
                    work     <= '0;
                    inv_flag <= has_bad_digit(a) | has_bad_digit(b);
                end
                PASS1: begin
                    if (inv_flag) begin
                        result    <= '0;
                        sign      <= 1'b0;
                        carry_out <= 1'b0;
                        invalid   <= 1'b1;
                    end else begin
                        a_sh  <= a_sh >> 4;
                        b_sh  <= b_sh >> 4;
                        work  <= work_next;
                        carry <= carry_n;
                        idx   <= idx + 1'b1;
                        if (last && op_r && !carry_n) begin
                            // No end carry: difference is in complement form.
                            carry <= 1'b1;
                            idx   <= '0;
                        end else if (last) begin
                            result    <= work_next;
                            sign      <= 1'b0;
                            carry_out <= op_r ? 1'b0 : carry_n;
                            invalid   <= 1'b0;
                        end
                    end
                end
                PASS2: begin
                    work  <= work_next;
                    carry <= carry_n;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        result    <= work_next;
                        sign      <= 1'b1;
                        carry_out <= 1'b0;
                        invalid   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - scoreboard bench for bcd_serial_addsub against an integer model
module tb_bcd_serial_addsub;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [15:0]   a = '0;
    logic [15:0]   b = '0;
    logic          op = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   result;
    logic          sign;
    logic          carry_out;
    logic          invalid;

    typedef struct {
        logic [15:0] res;
        logic        sgn;
        logic        cry;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 0;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sign(sign), .carry_out(carry_out), .invalid(invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'b0;
        else                      out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int from_bcd(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic bad_bcd(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v, input logic top);
        exp_t e;
        int x, y, s;
        e.res = '0; e.sgn = 1'b0; e.cry = 1'b0; e.inv = 1'b0; e.lat = D; e.acc = 0;
        if (bad_bcd(ta) || bad_bcd(tb_v)) begin
            e.inv = 1'b1;
            e.lat = 1;
        end else begin
            x = from_bcd(ta);
            y = from_bcd(tb_v);
            if (!top) begin
                s = x + y;
                e.cry = (s >= 10000);
                e.res = to_bcd(s % 10000);
            end else if (x >= y) begin
                e.res = to_bcd(x - y);
            end else begin
                e.res = to_bcd(y - x);
                e.sgn = 1'b1;
                e.lat = 2 * D;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic top);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            chk("start_ready_timeout", 32'(start_ready), 32'd1);
            return;
        end
        a = ta; b = tb_v; op = top; start_valid = 1'b1;
        e = model(ta, tb_v, top);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic monitor();
        exp_t cur;
        logic prev_v;
        logic [18:0] snap;
        prev_v = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        chk("result", 32'(result), 32'(cur.res));
                        chk("sign", 32'(sign), 32'(cur.sgn));
                        chk("carry_out", 32'(carry_out), 32'(cur.cry));
                        chk("invalid", 32'(invalid), 32'(cur.inv));
                    end
                    snap = {result, sign, carry_out, invalid};
                end else if (out_valid) begin
                    chk("hold_stable", 32'({result, sign, carry_out, invalid}), 32'(snap));
                end
                prev_v = out_valid;
            end
        end
    endtask

    initial begin
        int n;
        logic [15:0] ra, rb;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({sign, carry_out, invalid}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_start_ready", 32'(start_ready), 32'd1);

        issue(16'h1234, 16'h5678, 1'b0);
        issue(16'h9999, 16'h0001, 1'b0);
        issue(16'h5000, 16'h1234, 1'b1);
        issue(16'h1234, 16'h5000, 1'b1);
        issue(16'h0042, 16'h0042, 1'b1);
        issue(16'h0000, 16'h0001, 1'b1);
        issue(16'h9999, 16'h9999, 1'b0);
        drain();

        // Invalid digit with the consumer stalled; a stray start must be dropped.
        ready_mode = 1;
        issue(16'h12A4, 16'h0000, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_start_ready", 32'(start_ready), 32'd0);
            chk("stall_result", 32'({result, invalid}), 32'h1);
            start_valid = (i == 4);
            a = 16'h0001; b = 16'h0001; op = 1'b0;
            @(negedge clk);
        end
        start_valid = 1'b0;
        ready_mode = 0;
        drain();
        repeat (12) @(negedge clk);
        chk("stray_start_dropped", 32'(out_valid), 32'd0);

        // Reset in the middle of the recomplement pass.
        issue(16'h1234, 16'h5000, 1'b1);
        repeat (D + 1) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_outputs", 32'({result, sign, carry_out, invalid}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_start_ready", 32'(start_ready), 32'd1);
        issue(16'h0001, 16'h0002, 1'b0);
        drain();

        for (int k = 0; k < 150; k++) begin
            ready_mode = (k >= 75) ? 2 : 0;
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 19) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 19) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
